dcsr_stream: RTL
================

Name: dcsr_stream

Overview:
- Parametrised multi-lane circular-shift coefficient streamer for the accelerated polynomial multiplier.
- Holds LANES operand words of N bits each and emits one bit per lane per cycle (a LANES-bit coefficient slice) for N cycles per pass.
- Generalises the fixed 4x4 load-on-reset rotator: it adds a valid/ready load handshake, start/done pass control, selectable bit order, rotate-or-clear mode, abort and a pass counter.
- Sits between the operand buffer and the multiplier datapath.

Parameters:
- LANES, 4, number of parallel operand lanes (dcoef width).
- N, 4, bits per lane, which is also the pass length in cycles; N >= 2.
- PCW, 8, pass-counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; clears all state
- load_valid  in  1  load_data valid
- load_ready  out  1  block can accept a load
- load_data  in  LANES*N  lane i occupies bits [i*N +: N]
- start  in  1  begin one pass
- abort  in  1  terminate a running pass
- msb_first  in  1  0 = emit bit 0 first, 1 = emit bit N-1 first; sampled with start
- clear_mode  in  1  0 = rotate (contents preserved), 1 = shift in zeros (contents consumed); sampled with start
- dcoef  out  LANES  bit i = current output bit of lane i
- dcoef_valid  out  1  dcoef is valid this cycle
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the last slice
- pass_cnt  out  PCW  completed passes since the last load, saturating

Behaviour:
- States:
  - IDLE: empty.
  - LOADED: data held, no pass yet.
  - RUN: pass in progress.
  - DONE: pass finished, data retained.
- Reset (reset=0, asynchronous):
  - state=IDLE; all shift registers 0; bit counter 0; mode latches 0; pass_cnt 0.
  - Outputs: dcoef=0, dcoef_valid=0, busy=0, done=0, load_ready=1.
- Handshake and loading:
  - load_ready=1 in IDLE, LOADED and DONE; 0 in RUN.
  - A load is accepted on an edge where load_valid && load_ready. It copies load_data into the lanes, goes to LOADED and sets pass_cnt=0.
- Starting a pass:
  - start is honoured only in LOADED or DONE. It is ignored in IDLE and RUN.
  - If start and an accepted load coincide, the load wins and start is ignored.
  - On a start edge, msb_first and clear_mode are latched, the bit counter is set to 0 and state goes to RUN.
- Latency: start sampled at edge t gives first dcoef_valid in cycle t+1. Exactly N consecutive valid cycles follow, with no gaps.
- RUN, cycle k (k = 0..N-1):
  - dcoef[i] = lane i bit 0 (LSB order) or bit N-1 (MSB order).
  - dcoef_valid=1 and busy=1.
  - At the end-of-cycle edge, each lane shifts one place toward the output bit. In rotate mode the output bit re-enters at the far end; in clear mode a 0 enters.
- End of pass:
  - At the edge ending k=N-1, state goes to DONE, done=1 for exactly that first DONE cycle, and pass_cnt increments (saturating at all-ones).
  - Rotate mode: lanes then equal their pre-pass contents.
  - Clear mode: lanes are all zero.
- Idle outputs: outside RUN, dcoef=0 (gated) and dcoef_valid=0.
- Abort:
  - abort=1 in RUN sends state to DONE at the next edge, with no done pulse and no pass_cnt increment.
  - Lane contents are whatever partial rotation has been reached.
  - abort outside RUN is ignored; abort has priority over the final-cycle transition.
- Reset during RUN: immediate clear to IDLE; no done pulse.
- Widths:
  - Bit counter is clog2(N) bits.
  - Last cycle is detected by counter == N-1; no wrap-around beyond N-1 is possible.

Decomposition:
- Shared package dcsr_pkg:
  - State enum (IDLE, LOADED, RUN, DONE).
  - Bit-order and mode constants.
  - clog2-based counter-width function.
- One natural sub-module, dcsr_lane:
  - A single N-bit loadable shift register with direction and fill-select inputs and a 1-bit tap.
  - The top level instantiates LANES copies and adds the control FSM and counters.

Test Plan:
- Default parameters: load_data=16'h0F3A (lanes A,3,F,0), start with msb_first=0, clear_mode=0 -> dcoef 6,7,4,5 on 4 consecutive valid cycles; done pulses in the 5th cycle; pass_cnt=1.
- Same load, start with msb_first=1 -> dcoef 5,4,7,6; a second start without reloading repeats 5,4,7,6 and pass_cnt=2.
- Load 16'h0F3A, start with clear_mode=1 -> 6,7,4,5; a second start -> 0,0,0,0; pass_cnt=2.
- Assert load_valid and start in RUN cycle 1 -> load_ready=0, load ignored, start ignored, sequence unchanged.
- abort in RUN cycle 2 -> DONE next cycle, no done pulse, pass_cnt unchanged, load_ready=1.
- Pull reset low mid-RUN (between edges) -> dcoef, dcoef_valid and busy drop to 0 immediately; after release, start is ignored until a new load is accepted.

Source files
------------

// File: rtl/dcsr_pkg.sv
// Shared definitions for the circular-shift coefficient streamer.
// Contents: the FSM state enum, the bit-order and fill-mode encodings, and a
//           helper that sizes the per-pass bit counter.
package dcsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no operand held
    ST_LOADED = 2'd1,  // operand held, no pass run yet
    ST_RUN    = 2'd2,  // pass in progress
    ST_DONE   = 2'd3   // pass finished or aborted, operand retained
  } state_t;

  // Bit order: which end of a lane is presented first.
  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  // Fill mode: what re-enters the far end of a lane on each shift.
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_CLEAR  = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcsr_lane.sv
// One operand lane: an N-bit loadable shift register with a 1-bit output tap.
// Ports: clk/reset; load + data write the whole lane; shift moves it one place
//        toward the tap selected by order; mode picks rotate or zero fill; tap is the current output bit.
module dcsr_lane
  import dcsr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] data,
  input  logic         shift,
  input  logic         order,
  input  logic         mode,
  output logic         tap
);

  logic [N-1:0] q;
  logic         fill;

  assign tap  = (order == ORDER_LSB) ? q[0] : q[N-1];
  // Rotate feeds the outgoing bit back in at the far end; clear feeds zero.
  assign fill = (mode == MODE_ROTATE) ? tap : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      if (order == ORDER_LSB) begin
        q <= {fill, q[N-1:1]};
      end else begin
        q <= {q[N-2:0], fill};
      end
    end
  end

endmodule

// File: rtl/dcsr_stream.sv
// Multi-lane circular-shift coefficient streamer: emits one bit per lane per cycle for N cycles per pass.
// Ports: load_valid/load_ready/load_data load all lanes; start/abort/msb_first/clear_mode control a pass;
//        dcoef/dcoef_valid carry the slice; busy, done (1-cycle pulse) and pass_cnt report status.
module dcsr_stream
  import dcsr_pkg::*;
#(
  parameter int LANES = 4,
  parameter int N     = 4,
  parameter int PCW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [LANES*N-1:0] load_data,
  input  logic               start,
  input  logic               abort,
  input  logic               msb_first,
  input  logic               clear_mode,
  output logic [LANES-1:0]   dcoef,
  output logic               dcoef_valid,
  output logic               busy,
  output logic               done,
  output logic [PCW-1:0]     pass_cnt
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             order_q;
  logic             mode_q;
  logic             done_q;
  logic [LANES-1:0] taps;

  logic load_acc;
  logic start_acc;
  logic in_run;
  logic last;
  logic finish;

  assign in_run   = (state == ST_RUN);
  assign last     = (cnt == LAST_CNT);
  assign load_acc = load_valid && load_ready;
  // A coincident accepted load takes precedence over start.
  assign start_acc = start && !load_acc && ((state == ST_LOADED) || (state == ST_DONE));
  // Abort outranks the natural end of a pass, so a final-cycle abort gives no done/count.
  assign finish = in_run && last && !abort;

  // ---------------------------------------------------------------- lanes
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dcsr_lane #(.N(N)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load_acc),
      .data  (load_data[i*N +: N]),
      .shift (in_run),
      .order (order_q),
      .mode  (mode_q),
      .tap   (taps[i])
    );
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load_acc) state_next = ST_LOADED;
      end
      ST_LOADED, ST_DONE: begin
        if (load_acc)       state_next = ST_LOADED;
        else if (start_acc) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (abort || last) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    load_ready  = !in_run;
    busy        = in_run;
    dcoef_valid = in_run;
    dcoef       = in_run ? taps : '0;
    done        = done_q;
  end

  // ---------------------------------------------------------------- counters and mode latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      order_q <= 1'b0;
      mode_q  <= 1'b0;
    end else if (start_acc) begin
      cnt     <= '0;
      order_q <= msb_first;
      mode_q  <= clear_mode;
    end else if (in_run && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt <= '0;
    end else if (load_acc) begin
      pass_cnt <= '0;
    end else if (finish && (pass_cnt != '1)) begin
      pass_cnt <= pass_cnt + 1'b1;
    end
  end

endmodule
